// File: rtl/high_res_timer_pkg.sv
// Shared definitions for the high-resolution timer host.
// Holds the register map of the 16-bit interval timer slave, the control
// word bit positions and preset words, the host state encoding and the
// bus command record plus helpers that build write and read commands.
package high_res_timer_pkg;

    // Timer slave register map (word addresses).
    localparam logic [2:0] ADDR_STATUS   = 3'd0;
    localparam logic [2:0] ADDR_CONTROL  = 3'd1;
    localparam logic [2:0] ADDR_PERIOD_L = 3'd2;
    localparam logic [2:0] ADDR_PERIOD_H = 3'd3;
    localparam logic [2:0] ADDR_SNAP_L   = 3'd4;
    localparam logic [2:0] ADDR_SNAP_H   = 3'd5;

    // Control register bit positions.
    localparam int CTRL_ITO_BIT   = 0;
    localparam int CTRL_CONT_BIT  = 1;
    localparam int CTRL_START_BIT = 2;
    localparam int CTRL_STOP_BIT  = 3;

    localparam logic [15:0] CTRL_ITO   = 16'(1) << CTRL_ITO_BIT;
    localparam logic [15:0] CTRL_CONT  = 16'(1) << CTRL_CONT_BIT;
    localparam logic [15:0] CTRL_START = 16'(1) << CTRL_START_BIT;
    localparam logic [15:0] CTRL_STOP  = 16'(1) << CTRL_STOP_BIT;

    // Continuous run with interrupt enabled.
    localparam logic [15:0] CTRL_RUN_WORD = CTRL_ITO | CTRL_CONT | CTRL_START;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_WR_PL,
        ST_WR_PH,
        ST_WR_CTRL,
        ST_WAIT_IRQ,
        ST_CLR_ST,
        ST_WR_SNAP,
        ST_RD_SL,
        ST_RD_SH,
        ST_CAP_SH,
        ST_OUT,
        ST_WR_STOP
    } state_e;

    // One cycle of Avalon-MM master command.
    typedef struct packed {
        logic        cs;
        logic        write_n;
        logic [2:0]  address;
        logic [15:0] writedata;
    } av_cmd_t;

    localparam av_cmd_t AV_IDLE = '{cs: 1'b0, write_n: 1'b1, address: 3'd0, writedata: 16'h0000};

    function automatic av_cmd_t av_write(input logic [2:0] addr, input logic [15:0] data);
        return '{cs: 1'b1, write_n: 1'b0, address: addr, writedata: data};
    endfunction

    function automatic av_cmd_t av_read(input logic [2:0] addr);
        return '{cs: 1'b1, write_n: 1'b1, address: addr, writedata: 16'h0000};
    endfunction

endpackage

// File: rtl/high_res_timer_host.sv
// high_res_timer_host: Avalon-MM master for the 16-bit interval timer.
// Programs period and control, services each timeout interrupt, snapshots
// the live counter and emits a {count, snapshot} record on a valid/ready
// stream.
//
// Ports
//   clk, reset            single clock, synchronous active-high reset
//   cmd_start, cmd_stop   start pulse (IDLE only), stop request (latched)
//   cfg_period[31:0]      period sampled on accepted start (0 -> default)
//   av_*                  registered master command, read latency 1
//   av_readdata[15:0]     timer read data
//   timer_irq             level interrupt from the timer
//   busy                  high outside IDLE
//   evt_valid/evt_ready   record handshake
//   evt_count/evt_snapshot record payload
module high_res_timer_host
    import high_res_timer_pkg::*;
#(
    parameter logic [31:0] DEFAULT_PERIOD = 32'h0001_387F
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_start,
    input  logic        cmd_stop,
    input  logic [31:0] cfg_period,
    output logic [2:0]  av_address,
    output logic        av_chipselect,
    output logic        av_write_n,
    output logic [15:0] av_writedata,
    input  logic [15:0] av_readdata,
    input  logic        timer_irq,
    output logic        busy,
    output logic        evt_valid,
    input  logic        evt_ready,
    output logic [31:0] evt_count,
    output logic [31:0] evt_snapshot
);

    state_e      state_q, state_d;
    logic [31:0] period_q, period_d;
    logic        stop_q, stop_d;
    logic [31:0] count_q, count_d;
    logic [31:0] snap_q, snap_d;
    av_cmd_t     bus_q, bus_d;
    logic        valid_q, valid_d;

    // Next-state and datapath.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // it unassigned; otherwise synthesis infers a latch.
        state_d  = state_q;
        period_d = period_q;
        stop_d   = stop_q;
        count_d  = count_q;
        snap_d   = snap_q;

        if (state_q != ST_IDLE && cmd_stop) begin
            stop_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                // A simultaneous cmd_stop is dropped: stop_d only sets outside IDLE.
                if (cmd_start) begin
                    period_d = (cfg_period == 32'd0) ? DEFAULT_PERIOD : cfg_period;
                    count_d  = 32'd0;
                    state_d  = ST_WR_PL;
                end
            end
            ST_WR_PL:   state_d = ST_WR_PH;
            ST_WR_PH:   state_d = ST_WR_CTRL;
            ST_WR_CTRL: state_d = ST_WAIT_IRQ;
            ST_WAIT_IRQ: begin
                // Stop wins over a pending interrupt.
                if (stop_q || cmd_stop) begin
                    state_d = ST_WR_STOP;
                end else if (timer_irq) begin
                    state_d = ST_CLR_ST;
                end
            end
            ST_CLR_ST:  state_d = ST_WR_SNAP;
            ST_WR_SNAP: state_d = ST_RD_SL;
            ST_RD_SL:   state_d = ST_RD_SH;
            ST_RD_SH: begin
                // Data for the snap_l read issued in RD_SL arrives now.
                snap_d[15:0] = av_readdata;
                state_d      = ST_CAP_SH;
            end
            ST_CAP_SH: begin
                snap_d[31:16] = av_readdata;
                count_d       = count_q + 32'd1;
                state_d       = ST_OUT;
            end
            ST_OUT: begin
                if (evt_ready) begin
                    state_d = ST_WAIT_IRQ;
                end
            end
            ST_WR_STOP: begin
                stop_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Bus command decoded from the state being entered, so the registered
    // outputs line up with the state register cycle for cycle.
    always_comb begin
        bus_d = AV_IDLE;
        case (state_d)
            ST_WR_PL:   bus_d = av_write(ADDR_PERIOD_L, period_d[15:0]);
            ST_WR_PH:   bus_d = av_write(ADDR_PERIOD_H, period_d[31:16]);
            ST_WR_CTRL: bus_d = av_write(ADDR_CONTROL, CTRL_RUN_WORD);
            ST_CLR_ST:  bus_d = av_write(ADDR_STATUS, 16'h0000);
            ST_WR_SNAP: bus_d = av_write(ADDR_SNAP_L, 16'h0000);
            ST_RD_SL:   bus_d = av_read(ADDR_SNAP_L);
            ST_RD_SH:   bus_d = av_read(ADDR_SNAP_H);
            ST_WR_STOP: bus_d = av_write(ADDR_CONTROL, CTRL_STOP);
            default:    bus_d = AV_IDLE;
        endcase
        valid_d = (state_d == ST_OUT);
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples the
        // pre-edge value of every other register.
        if (reset) begin
            state_q  <= ST_IDLE;
            period_q <= 32'd0;
            stop_q   <= 1'b0;
            count_q  <= 32'd0;
            snap_q   <= 32'd0;
            bus_q    <= AV_IDLE;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            period_q <= period_d;
            stop_q   <= stop_d;
            count_q  <= count_d;
            snap_q   <= snap_d;
            bus_q    <= bus_d;
            valid_q  <= valid_d;
        end
    end

    assign av_chipselect = bus_q.cs;
    assign av_write_n    = bus_q.write_n;
    assign av_address    = bus_q.address;
    assign av_writedata  = bus_q.writedata;
    assign busy          = (state_q != ST_IDLE);
    assign evt_valid     = valid_q;
    assign evt_count     = count_q;
    assign evt_snapshot  = snap_q;

endmodule

// File: tb/tb_high_res_timer_host.sv
// Testbench for high_res_timer_host. Contains a behavioural interval timer
// slave, a timeline model of the expected master behaviour checked every
// cycle, and directed scenarios with hand-computed literal expectations.
module tb_high_res_timer_host;

    localparam logic [31:0] DEF_PERIOD = 32'h0001_387F;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        por = 1'b1;
    logic        cmd_start = 1'b0;
    logic        cmd_stop = 1'b0;
    logic [31:0] cfg_period = 32'd0;
    logic [2:0]  av_address;
    logic        av_chipselect;
    logic        av_write_n;
    logic [15:0] av_writedata;
    logic [15:0] av_readdata;
    logic        timer_irq;
    logic        busy;
    logic        evt_valid;
    logic        evt_ready = 1'b1;
    logic [31:0] evt_count;
    logic [31:0] evt_snapshot;

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    high_res_timer_host #(.DEFAULT_PERIOD(DEF_PERIOD)) dut (
        .clk          (clk),
        .reset        (reset),
        .cmd_start    (cmd_start),
        .cmd_stop     (cmd_stop),
        .cfg_period   (cfg_period),
        .av_address   (av_address),
        .av_chipselect(av_chipselect),
        .av_write_n   (av_write_n),
        .av_writedata (av_writedata),
        .av_readdata  (av_readdata),
        .timer_irq    (timer_irq),
        .busy         (busy),
        .evt_valid    (evt_valid),
        .evt_ready    (evt_ready),
        .evt_count    (evt_count),
        .evt_snapshot (evt_snapshot)
    );

    // ---------------- interval timer slave ----------------
    // Reset only at power-on so a host reset leaves the timer untouched.
    logic        slave_rst_n;
    logic [15:0] s_pl, s_ph;
    logic [31:0] s_cnt, s_snap;
    logic        s_to, s_run, s_cont, s_ito;
    assign slave_rst_n = !(reset && por);
    assign timer_irq = s_to && s_ito;

    always @(posedge clk) begin
        if (!slave_rst_n) begin
            s_pl <= '0; s_ph <= '0; s_cnt <= '0; s_snap <= '0;
            s_to <= 1'b0; s_run <= 1'b0; s_cont <= 1'b0; s_ito <= 1'b0;
            av_readdata <= '0;
        end else begin
            if (s_run) begin
                if (s_cnt == 32'd0) begin
                    s_cnt <= {s_ph, s_pl};
                    s_to  <= 1'b1;
                    if (!s_cont) s_run <= 1'b0;
                end else begin
                    s_cnt <= s_cnt - 32'd1;
                end
            end
            if (av_chipselect && !av_write_n) begin
                case (av_address)
                    3'd0: s_to <= 1'b0;
                    3'd1: begin
                        s_ito  <= av_writedata[0];
                        s_cont <= av_writedata[1];
                        if (av_writedata[2]) begin
                            s_run <= 1'b1;
                            s_cnt <= {s_ph, s_pl};
                        end
                        if (av_writedata[3]) s_run <= 1'b0;
                    end
                    3'd2: s_pl <= av_writedata;
                    3'd3: s_ph <= av_writedata;
                    3'd4, 3'd5: s_snap <= s_cnt;
                    default: ;
                endcase
            end
            if (av_chipselect && av_write_n) begin
                case (av_address)
                    3'd0: av_readdata <= {14'd0, s_run, s_to};
                    3'd1: av_readdata <= {12'd0, 1'b0, s_run, s_cont, s_ito};
                    3'd2: av_readdata <= s_pl;
                    3'd3: av_readdata <= s_ph;
                    3'd4: av_readdata <= s_snap[15:0];
                    3'd5: av_readdata <= s_snap[31:16];
                    default: av_readdata <= 16'h0000;
                endcase
            end
        end
    end

    // ---------------- timeline model ----------------
    // Phases of the host as seen from outside; m_t0 is the cycle that
    // triggered the current phase (accepted start or interrupt).
    typedef enum {M_IDLE, M_START, M_WAIT, M_SERV, M_OFFER, M_STOP} mphase_e;
    mphase_e     m_phase = M_IDLE;
    int          m_t0 = 0;
    logic [31:0] m_period = 32'd0;
    logic [31:0] m_count = 32'd0;
    bit          m_stop = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            m_phase = M_IDLE;
            m_count = 32'd0;
            m_stop  = 1'b0;
        end else begin
            if (m_phase != M_IDLE && cmd_stop) m_stop = 1'b1;
            case (m_phase)
                M_IDLE: if (cmd_start) begin
                    m_phase  = M_START;
                    m_t0     = cyc;
                    m_period = (cfg_period == 32'd0) ? DEF_PERIOD : cfg_period;
                    m_count  = 32'd0;
                end
                M_START: if (cyc - m_t0 == 3) m_phase = M_WAIT;
                M_WAIT: begin
                    if (m_stop) m_phase = M_STOP;
                    else if (timer_irq) begin
                        m_phase = M_SERV;
                        m_t0    = cyc;
                    end
                end
                M_SERV: if (cyc - m_t0 == 5) begin
                    m_phase = M_OFFER;
                    m_count = m_count + 32'd1;
                end
                M_OFFER: if (evt_ready) m_phase = M_WAIT;
                M_STOP: begin
                    m_stop  = 1'b0;
                    m_phase = M_IDLE;
                end
                default: m_phase = M_IDLE;
            endcase
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Per-cycle comparison against the model.
    logic        e_cs, e_wn, e_val, e_chk_a, e_chk_d;
    logic [2:0]  e_addr;
    logic [15:0] e_wd;
    int          e_d;

    always @(negedge clk) begin
        if (cmp_en) begin
            e_cs = 1'b0; e_wn = 1'b1; e_val = 1'b0; e_chk_a = 1'b0; e_chk_d = 1'b0;
            e_addr = 3'd0; e_wd = 16'h0000;
            e_d = cyc - m_t0;
            case (m_phase)
                M_START: begin
                    e_cs = 1'b1; e_wn = 1'b0; e_chk_a = 1'b1; e_chk_d = 1'b1;
                    if (e_d == 1) begin e_addr = 3'd2; e_wd = m_period[15:0]; end
                    else if (e_d == 2) begin e_addr = 3'd3; e_wd = m_period[31:16]; end
                    else begin e_addr = 3'd1; e_wd = 16'h0007; end
                end
                M_SERV: begin
                    if (e_d <= 4) begin
                        e_cs = 1'b1; e_chk_a = 1'b1;
                    end
                    if (e_d == 1) begin e_wn = 1'b0; e_chk_d = 1'b1; e_addr = 3'd0; end
                    if (e_d == 2) begin e_wn = 1'b0; e_chk_d = 1'b1; e_addr = 3'd4; end
                    if (e_d == 3) e_addr = 3'd4;
                    if (e_d == 4) e_addr = 3'd5;
                end
                M_OFFER: e_val = 1'b1;
                M_STOP: begin
                    e_cs = 1'b1; e_wn = 1'b0; e_chk_a = 1'b1; e_chk_d = 1'b1;
                    e_addr = 3'd1; e_wd = 16'h0008;
                end
                default: ;
            endcase
            check("av_chipselect", 32'(av_chipselect), 32'(e_cs));
            check("av_write_n", 32'(av_write_n), 32'(e_wn));
            check("busy", 32'(busy), 32'(m_phase != M_IDLE));
            check("evt_valid", 32'(evt_valid), 32'(e_val));
            check("evt_count", evt_count, m_count);
            if (e_chk_a) check("av_address", 32'(av_address), 32'(e_addr));
            if (e_chk_d) check("av_writedata", 32'(av_writedata), 32'(e_wd));
            if (e_val) check("evt_snapshot", evt_snapshot, s_snap);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic pulse_start(input logic [31:0] per, input logic with_stop, output int t);
        @(posedge clk); #1;
        cfg_period = per; cmd_start = 1'b1; cmd_stop = with_stop; t = cyc;
        @(posedge clk); #1;
        cmd_start = 1'b0; cmd_stop = 1'b0;
    endtask

    task automatic wait_valid(input int budget, output int waited);
        waited = 0;
        while (evt_valid !== 1'b1 && waited < budget) begin
            @(negedge clk);
            waited++;
        end
        check("evt_valid_arrival", 32'(evt_valid), 32'd1);
    endtask

    task automatic expect_write(input string name, input logic [2:0] a, input logic [15:0] d);
        check({name, "_cs"}, 32'(av_chipselect), 32'd1);
        check({name, "_wn"}, 32'(av_write_n), 32'd0);
        check({name, "_addr"}, 32'(av_address), 32'(a));
        check({name, "_data"}, 32'(av_writedata), 32'(d));
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, t2, w, n;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0; por = 1'b0;
        cmp_en = 1'b1;

        // Reset state.
        @(negedge clk);
        check("rst_cs", 32'(av_chipselect), 32'd0);
        check("rst_wn", 32'(av_write_n), 32'd1);
        check("rst_addr", 32'(av_address), 32'd0);
        check("rst_wd", 32'(av_writedata), 32'd0);
        check("rst_valid", 32'(evt_valid), 32'd0);
        check("rst_count", evt_count, 32'd0);
        check("rst_snap", evt_snapshot, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);

        // Default period when cfg_period is 0, then stop while waiting.
        pulse_start(32'd0, 1'b0, t0);
        @(negedge clk); expect_write("def_pl", 3'd2, 16'h387F);
        @(negedge clk); expect_write("def_ph", 3'd3, 16'h0001);
        @(negedge clk); expect_write("def_ctrl", 3'd1, 16'h0007);
        @(negedge clk);
        check("def_wait_cs", 32'(av_chipselect), 32'd0);
        check("def_wait_busy", 32'(busy), 32'd1);
        @(posedge clk); #1 cmd_stop = 1'b1;
        @(posedge clk); #1 cmd_stop = 1'b0;
        @(negedge clk); expect_write("def_stop", 3'd1, 16'h0008);
        @(negedge clk); check("def_idle_busy", 32'(busy), 32'd0);

        // Period 99 with the consumer stalled: first record timing and
        // content, then 300 stalled cycles whose timeouts coalesce.
        evt_ready = 1'b0;
        pulse_start(32'd99, 1'b0, t0);
        wait_valid(200, w);
        check("first_rec_latency", 32'(cyc - t0), 32'd110);
        check("first_rec_count", evt_count, 32'd1);
        check("first_rec_snap", evt_snapshot, 32'd97);
        repeat (300) @(negedge clk);
        check("held_valid", 32'(evt_valid), 32'd1);
        check("held_count", evt_count, 32'd1);
        check("held_snap", evt_snapshot, 32'd97);
        @(posedge clk); #1 evt_ready = 1'b1;
        @(negedge clk);
        @(negedge clk); check("after_hs_valid", 32'(evt_valid), 32'd0);
        wait_valid(20, w);
        check("coalesced_latency", 32'(w), 32'd6);
        check("coalesced_count", evt_count, 32'd2);
        @(negedge clk);
        wait_valid(120, w);
        check("third_rec_phase", 32'((cyc - t0) % 100), 32'd10);
        check("third_rec_count", evt_count, 32'd3);

        // Stop requested while a record is being offered.
        @(posedge clk); #1 evt_ready = 1'b0;
        @(negedge clk);
        wait_valid(120, w);
        @(posedge clk); #1 cmd_stop = 1'b1;
        @(posedge clk); #1 cmd_stop = 1'b0; evt_ready = 1'b1;
        @(negedge clk); check("stop_out_valid", 32'(evt_valid), 32'd1);
        @(negedge clk); check("stop_wait_cs", 32'(av_chipselect), 32'd0);
        @(negedge clk); expect_write("stop_wr", 3'd1, 16'h0008);
        @(negedge clk); check("stop_idle_busy", 32'(busy), 32'd0);
        repeat (300) @(negedge clk);
        check("stop_timer_halted", 32'(s_run), 32'd0);
        check("stop_count_kept", evt_count, 32'd4);

        // Start and stop in the same IDLE cycle; later start while busy.
        pulse_start(32'd99, 1'b1, t2);
        @(negedge clk); check("ss_busy", 32'(busy), 32'd1);
        wait_valid(130, w);
        check("ss_rec_latency", 32'(cyc - t2), 32'd110);
        check("ss_rec_count", evt_count, 32'd1);
        @(posedge clk); #1 cfg_period = 32'd5; cmd_start = 1'b1;
        @(posedge clk); #1 cmd_start = 1'b0;
        @(negedge clk);
        wait_valid(130, w);
        check("ignored_start_interval", 32'(cyc - t2), 32'd210);
        check("ignored_start_count", evt_count, 32'd2);

        // Reset while the snap_h read is on the bus.
        n = 0;
        while (!(av_chipselect === 1'b1 && av_write_n === 1'b1 && av_address === 3'd5) && n < 150) begin
            @(negedge clk);
            n++;
        end
        check("rd_sh_reached", 32'(av_address), 32'd5);
        reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_cs", 32'(av_chipselect), 32'd0);
        check("mid_rst_valid", 32'(evt_valid), 32'd0);
        check("mid_rst_count", evt_count, 32'd0);
        check("mid_rst_snap", evt_snapshot, 32'd0);
        repeat (5) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/high_res_timer_host.md
# high_res_timer_host

Avalon-MM master that drives the 16-bit-register interval timer slave: programs period and control, services each timeout interrupt, snapshots the live counter and emits a timestamped event record on a valid/ready stream. Sits between the timer slave (bus side) and the acquisition logic that needs per-period ticks with sub-period latency information.

## Interface
- `DEFAULT_PERIOD`, 32'h0001_387F: period loaded when `cfg_period` is 0 at start.
- `clk` in 1: single clock; also clocks the timer slave.
- `reset` in 1: synchronous, active-high; one clock; reset is synchronous and active-high.
- `cmd_start` in 1: pulse; program and start the timer (ignored unless IDLE).
- `cmd_stop` in 1: pulse; request stop (latched, see Operation).
- `cfg_period` in 32: timer period, sampled on accepted `cmd_start`.
- `av_address` out 3, `av_chipselect` out 1, `av_write_n` out 1, `av_writedata` out 16: master command to timer.
- `av_readdata` in 16: timer read data, fixed latency 1, no waitrequest.
- `timer_irq` in 1: level interrupt from timer.
- `busy` out 1: high in any state except IDLE.
- `evt_valid` out 1, `evt_ready` in 1, `evt_count` out 32, `evt_snapshot` out 32: event record stream.

## Operation
- Timer map: 0 status (write clears TO), 1 control {STOP,START,CONT,ITO}, 2 period_l, 3 period_h, 4 snap_l, 5 snap_h (write either latches counter).
- States: IDLE, WR_PL, WR_PH, WR_CTRL, WAIT_IRQ, CLR_ST, WR_SNAP, RD_SL, RD_SH, CAP_SH, OUT, WR_STOP.
- IDLE + `cmd_start`: latch period (`cfg_period` or `DEFAULT_PERIOD` if 0), clear `evt_count`, -> WR_PL.
- WR_PL: write period[15:0] to 2. WR_PH: write period[31:16] to 3. WR_CTRL: write 16'h0007 (ITO, CONT, START) to 1. -> WAIT_IRQ.
- WAIT_IRQ: if stop pending -> WR_STOP; else if `timer_irq` -> CLR_ST; else hold. Stop has priority over irq.
- CLR_ST: write 0 to 0. WR_SNAP: write 0 to 4. RD_SL: read 4. RD_SH: read 5, capture `av_readdata` as snapshot[15:0]. CAP_SH: capture snapshot[31:16], `evt_count` += 1 (wraps 2^32-1 -> 0). -> OUT.
- OUT: `evt_valid`=1; on `evt_ready` -> WAIT_IRQ. Record stable while valid.
- WR_STOP: write 16'h0008 to 1, clear stop pending -> IDLE.
- `cmd_stop` in any non-IDLE state sets stop pending; in IDLE ignored. `cmd_start` and `cmd_stop` same cycle in IDLE: start accepted, stop dropped.
- Timeouts occurring while not in WAIT_IRQ coalesce in the slave's sticky flag: one record only. Snapshot value exposes service latency (period - snapshot cycles).

## Timing
- Reset values: `av_chipselect`=0, `av_write_n`=1, `av_address`=0, `av_writedata`=0, `evt_valid`=0, `evt_count`=0, `evt_snapshot`=0, `busy`=0, stop pending=0, state IDLE.
- All bus outputs registered; each write state drives exactly one cycle of chipselect=1, write_n=0; `av_chipselect`=0 in IDLE, WAIT_IRQ, CAP_SH, OUT.
- Read: address presented cycle N, data sampled at end of N+1; RD_SL/RD_SH back-to-back.
- Start-to-running: `cmd_start` cycle T; writes in T+1, T+2, T+3; WAIT_IRQ at T+4.
- Irq-to-record: `timer_irq` seen cycle I in WAIT_IRQ; `evt_valid` at I+6; irq deasserts by I+3.
- `evt_ready` held high: OUT lasts one cycle.
- Reset mid-operation: returns to IDLE next edge, bus idle; timer slave state not touched.

## Structure
- Shared package `high_res_timer_pkg`: register address constants, control bit positions, START/CONT/ITO/STOP words, state enum.
- Single module; no sub-module. Bench pairs it with the existing timer slave, active-low reset derived from `reset`.

## Test plan
- Start with `cfg_period`=99: writes 99/0/0x0007 to 2/3/1 in 3 cycles; first record `evt_count`=1 about 100 cycles later, snapshot in [90,99].
- `cfg_period`=0: period writes 0x387F to 2, 0x0001 to 3.
- `evt_ready` low 300 cycles, period 99: one record held stable; next record count=2; multiple timeouts coalesce.
- `cmd_stop` during OUT: after handshake, write 0x0008 to 1, IDLE, no further irq.
- `cmd_start` and `cmd_stop` same IDLE cycle: timer starts, runs; `cmd_start` while busy ignored.
- Reset asserted in RD_SH: next cycle IDLE, chipselect 0, `evt_valid` 0, `evt_count` 0.
